// File: rtl/bulls_cows_game.sv
// Two-player Bulls & Cows game controller: secret entry, alternating scored guesses, win/draw detection.
// Optional macro ATTEMPT_LIMIT_EN ends the game in DRAW once player 2 has used MAX_ATTEMPTS guesses.
//   state   | meaning
//   SECRET1 | waiting for player 1 secret
//   SECRET2 | waiting for player 2 secret
//   GUESS   | waiting for current player's guess
//   SHOW    | last score displayed, press hands over the turn
//   WIN     | a player guessed the opponent's secret
//   DRAW    | player 2 ran out of attempts
module bulls_cows_game #(
    parameter int DIGIT_MAX    = 9,
    parameter int ATT_W        = 8,
    parameter int MAX_ATTEMPTS = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             confirma,
    input  logic [15:0]      SW,
    output logic [2:0]       phase,
    output logic             turn,
    output logic [2:0]       bulls,
    output logic [2:0]       cows,
    output logic             err,
    output logic             winner,
    output logic [ATT_W-1:0] attempts_p1,
    output logic [ATT_W-1:0] attempts_p2
);

    typedef enum logic [2:0] {
        SECRET1 = 3'd0,
        SECRET2 = 3'd1,
        GUESS   = 3'd2,
        SHOW    = 3'd3,
        WIN     = 3'd4,
        DRAW    = 3'd5
    } phase_t;

    localparam logic [3:0]       DMAX = DIGIT_MAX[3:0];
    localparam logic [ATT_W-1:0] AMAX = MAX_ATTEMPTS[ATT_W-1:0];

    phase_t           state;
    logic             confirma_q;
    logic [15:0]      secret1;
    logic [15:0]      secret2;
    logic             press;
    logic             sw_valid;
    logic [15:0]      opp;
    logic [2:0]       bulls_c;
    logic [2:0]       cows_c;
    logic [ATT_W-1:0] att_cur;
    logic [ATT_W-1:0] att_next;
    logic             limit_hit;

    assign phase = state;

    always_comb begin
        press    = confirma & ~confirma_q;
        opp      = turn ? secret1 : secret2;
        sw_valid = 1'b1;
        bulls_c  = 3'd0;
        cows_c   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (SW[4*i +: 4] > DMAX)
                sw_valid = 1'b0;
            for (int j = 0; j < 4; j++) begin
                if (j > i && SW[4*i +: 4] == SW[4*j +: 4])
                    sw_valid = 1'b0;
                if (SW[4*i +: 4] == opp[4*j +: 4]) begin
                    if (i == j) bulls_c = bulls_c + 3'd1;
                    else        cows_c  = cows_c + 3'd1;
                end
            end
        end
        att_cur  = turn ? attempts_p2 : attempts_p1;
        att_next = (&att_cur) ? att_cur : att_cur + 1'b1;
`ifdef ATTEMPT_LIMIT_EN
        limit_hit = turn && (att_next == AMAX);
`else
        limit_hit = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SECRET1;
            confirma_q  <= 1'b1;
            turn        <= 1'b0;
            bulls       <= 3'd0;
            cows        <= 3'd0;
            err         <= 1'b0;
            winner      <= 1'b0;
            attempts_p1 <= '0;
            attempts_p2 <= '0;
            secret1     <= 16'h0;
            secret2     <= 16'h0;
        end else begin
            confirma_q <= confirma;
            case (state)
                SECRET1: if (press) begin
                    err <= ~sw_valid;
                    if (sw_valid) begin
                        secret1 <= SW;
                        state   <= SECRET2;
                    end
                end
                SECRET2: if (press) begin
                    err <= ~sw_valid;
                    if (sw_valid) begin
                        secret2 <= SW;
                        turn    <= 1'b0;
                        state   <= GUESS;
                    end
                end
                GUESS: if (press) begin
                    err <= ~sw_valid;
                    if (sw_valid) begin
                        bulls <= bulls_c;
                        cows  <= cows_c;
                        if (turn) attempts_p2 <= att_next;
                        else      attempts_p1 <= att_next;
                        if (bulls_c == 3'd4) begin
                            state  <= WIN;
                            winner <= turn;
                        end else if (limit_hit) begin
                            state <= DRAW;
                        end else begin
                            state <= SHOW;
                        end
                    end
                end
                SHOW: if (press) begin
                    err   <= 1'b0;
                    turn  <= ~turn;
                    state <= GUESS;
                end
                WIN, DRAW: if (press) err <= 1'b0;
                default: state <= SECRET1;
            endcase
        end
    end

endmodule

// File: doc/bulls_cows_game.md
Name: bulls_cows_game

Overview:
Game-control core for the two-player Bulls & Cows game on the Nexys A7. It sits between the board top level and the 7-segment/LED drivers. It takes four decimal digits from SW[15:0] on each press of confirma. It stores each player's secret, scores guesses in alternating turns, and publishes phase, turn, bulls/cows, error and attempt counts for the display stage.

Parameters:
DIGIT_MAX, 9, largest legal digit value per nibble
ATT_W, 8, width of per-player attempt counters
MAX_ATTEMPTS, 10, guesses allowed per player (used only with ATTEMPT_LIMIT_EN)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high; restarts the game
confirma  input  1  raw level of the confirm button (already debounced); block edge-detects it
SW  input  16  digit entry; d3=SW[15:12], d2=SW[11:8], d1=SW[7:4], d0=SW[3:0]
phase  output  3  0=SECRET1, 1=SECRET2, 2=GUESS, 3=SHOW, 4=WIN, 5=DRAW
turn  output  1  current guesser; 0=player1, 1=player2
bulls  output  3  right digit in right position, 0..4
cows  output  3  right digit in wrong position, 0..4
err  output  1  last press was rejected
winner  output  1  winning player; valid only in WIN
attempts_p1  output  ATT_W  player1 guesses scored
attempts_p2  output  ATT_W  player2 guesses scored

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - phase=SECRET1; turn=0; bulls=0; cows=0; err=0; winner=0; attempts=0.
  - secret1=secret2=16'h0.
  - confirma_q=1, so a button held through reset does not fire.
- press = confirma & ~confirma_q. confirma_q is registered every cycle. At most one press is acted on per rising edge.
- valid(SW): every nibble <= DIGIT_MAX and all four nibbles pairwise distinct.
- Every press sets err <= ~valid(SW).
  - An invalid press changes nothing else: no state change, no store, no counter change.
  - The exception is SHOW, WIN and DRAW, where SW is not checked and err <= 0.
- State transitions (all take effect one cycle after the press cycle):
  - SECRET1 + valid press: secret1 <= SW; phase <= SECRET2.
  - SECRET2 + valid press: secret2 <= SW; phase <= GUESS; turn <= 0.
  - GUESS + valid press: score SW against the opponent's secret (turn=0 uses secret2, turn=1 uses secret1).
    - Register bulls and cows. Increment the guesser's attempt counter; counters saturate at all-ones.
    - If bulls==4: phase <= WIN; winner <= turn.
    - Otherwise phase <= SHOW.
  - SHOW + press: turn <= ~turn; phase <= GUESS. bulls and cows hold their last values until the next scored guess.
  - WIN / DRAW: presses ignored. Only reset leaves these states.
- Scoring:
  - bulls = count of i where g[i]==s[i].
  - cows = count of pairs (i,j), i!=j, where g[i]==s[j].
  - Both are computed combinationally from SW and the stored secret and registered on the press. Because digits are distinct, bulls+cows <= 4.
- Reset asserted in any state, including the press cycle, wins over the press: the next state is the reset state.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Illegal phase encodings (6, 7) recover to SECRET1 on the next clock.

Optional Feature:
ATTEMPT_LIMIT_EN
- Defined: checked in GUESS only when the scored guess has bulls != 4.
  - After the guess that makes attempts_p2 reach MAX_ATTEMPTS with no winner, phase <= DRAW instead of SHOW.
  - A player-1 guess that reaches MAX_ATTEMPTS still goes to SHOW.
  - A winning guess always goes to WIN.
- Undefined: no limit; the game continues until WIN, DRAW is unreachable, and the counters saturate.

Test Plan:
- Hold confirma=1 through reset release, then keep it high 5 cycles -> phase stays 0, err=0; release and press with SW=16'h1234 -> phase=1.
- Secrets 16'h1234 (P1), 16'h5678 (P2); P1 guesses 16'h8765 -> phase=3, bulls=0, cows=4, attempts_p1=1, turn=0; press -> phase=2, turn=1.
- In GUESS, SW=16'h1123, then SW=16'h12A4 -> err=1 each time, phase=2, attempts unchanged; SW=16'h5679 (turn 0) -> err=0, bulls=3, cows=0.
- P2 guesses 16'h1243 against secret1 16'h1234 -> bulls=2, cows=2; next P1 guesses 16'h5678 -> phase=4, winner=0, bulls=4; further presses -> no change; reset -> phase=0, secrets cleared.
- Reset asserted in the same cycle as a valid GUESS press -> phase=0, attempts=0, bulls=0, cows=0.
- With ATTEMPT_LIMIT_EN and MAX_ATTEMPTS=2, four non-winning guesses (P1, P2, P1, P2) -> phase=5 after the 4th, attempts_p1=attempts_p2=2; without the macro -> phase=3.
